// File: rtl/pulse_regen.sv
// pulse_regen: turns one-cycle event pulses into clean level waveforms.
// Each accepted event yields one HIGH_CYCLES-wide high phase followed by a
// LOW_CYCLES-wide low gap; events arriving while busy are queued (up to
// 2^PEND_W-1) and replayed back to back. A dropped event sets sticky ovf.
//
// Optional build macro: PULSE_REGEN_RETRIGGER_EN
//   When defined, an event arriving during the high phase reloads the high
//   counter (extending the current phase) instead of being queued.
//   When undefined, no reload path exists and such events are queued.

module pulse_regen #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              r,
    input  logic              in,
    input  logic              clr_ovf,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic              start;
    logic              absorb;
    logic              accept;
    logic              consume;
    logic              drop;
    logic              cnt_zero;

    // Event bookkeeping: decide whether this cycle starts a phase, queues,
    // absorbs or drops the incoming event.
    always_comb begin
        cnt_zero = (cnt == '0);
        start    = in || (pend_cnt != '0);
        absorb   = 1'b0;
`ifdef PULSE_REGEN_RETRIGGER_EN
        absorb   = in && (state == HIGH);
`endif
        accept   = in && !absorb;
        consume  = start && ((state == IDLE) || ((state == LOW) && cnt_zero));
        drop     = accept && !consume && (pend_cnt == PEND_MAX);
    end

    // Phase sequencer: IDLE -> HIGH -> LOW -> (HIGH | IDLE), outputs registered.
    always_ff @(posedge clk) begin
        if (!r) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        out   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
`ifdef PULSE_REGEN_RETRIGGER_EN
                    if (absorb) begin
                        cnt <= HIGH_LOAD;
                    end else
`endif
                    if (cnt_zero) begin
                        state <= LOW;
                        cnt   <= LOW_LOAD;
                        out   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt_zero) begin
                        if (start) begin
                            state <= HIGH;
                            cnt   <= HIGH_LOAD;
                            out   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pending-event counter: saturates at PEND_MAX, never wraps.
    always_ff @(posedge clk) begin
        if (!r) begin
            pend_cnt <= '0;
        end else if (consume) begin
            if ((pend_cnt != '0) && !accept) begin
                pend_cnt <= pend_cnt - PEND_W'(1);
            end
        end else if (accept && !drop) begin
            pend_cnt <= pend_cnt + PEND_W'(1);
        end
    end

    // Sticky overflow flag: a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (!r) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_regen.sv
// Bench for pulse_regen: timestamp-based reference model feeding a scoreboard
// queue; a monitor pops one expected vector per clock and compares.

module tb_pulse_regen;

    localparam int unsigned H      = 4;
    localparam int unsigned L      = 4;
    localparam int unsigned PEND_W = 3;
    localparam int          PMAX   = (1 << PEND_W) - 1;
`ifdef PULSE_REGEN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef struct packed {
        logic              out;
        logic              busy;
        logic [PEND_W-1:0] pend;
        logic              ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              r   = 1'b0;
    logic              ev  = 1'b0;
    logic              clr = 1'b0;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              ovf;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: times are edge indices.
    int m_k = 0;
    bit m_active = 1'b0;
    int m_high_end = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;

    pulse_regen #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .CNT_W      (16),
        .PEND_W     (PEND_W)
    ) dut (
        .clk     (clk),
        .r       (r),
        .in      (ev),
        .clr_ovf (clr),
        .out     (out),
        .busy    (busy),
        .pend_cnt(pend_cnt),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Advance the model by one edge with the given sampled inputs.
    function automatic exp_t model_step(input bit i, input bit c, input bit rr);
        exp_t e;
        bit free, in_high, absorbed, accept, consume, drop;
        m_k++;
        if (!rr) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
        end else begin
            free     = !m_active || (m_k >= m_high_end + int'(L));
            if (free) m_active = 1'b0;
            in_high  = m_active && (m_k <= m_high_end);
            absorbed = RETRIG && in_high && i;
            if (absorbed) m_high_end = m_k + int'(H);
            accept   = i && !absorbed;
            consume  = free && (i || m_pend > 0);
            drop     = 1'b0;
            if (consume) begin
                m_active   = 1'b1;
                m_high_end = m_k + int'(H);
                if (m_pend > 0 && !accept) m_pend--;
            end else if (accept) begin
                if (m_pend == PMAX) drop = 1'b1;
                else m_pend++;
            end
            if (drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        e.out  = m_active && (m_k < m_high_end);
        e.busy = m_active;
        e.pend = PEND_W'(m_pend);
        e.ovf  = m_ovf;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic cyc(input bit i, input bit c, input bit rr);
        @(negedge clk);
        ev  = i;
        clr = c;
        r   = rr;
        exp_q.push_back(model_step(i, c, rr));
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one expected vector per clock, sampled after the edge.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (mon_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at t=%0t: no expected vector queued", $time);
            end else begin
                e = exp_q.pop_front();
                a = '{out: out, busy: busy, pend: pend_cnt, ovf: ovf};
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs at t=%0t: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                             $time, a.out, a.busy, a.pend, a.ovf, e.out, e.busy, e.pend, e.ovf);
                end
            end
        end
    end

    initial begin
        int dens;
        // Reset held while in toggles.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(5);
        // Single pulse.
        cyc(1'b1, 1'b0, 1'b1);
        idle(15);
        // Three back-to-back pulses.
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        idle(30);
        // Long burst to saturate the queue, then one more to overflow.
        repeat (10) cyc(1'b1, 1'b0, 1'b1);
        idle(4);
        cyc(1'b0, 1'b1, 1'b1);
        idle(80);
        // Drop coinciding with clr_ovf: set must win.
        repeat (9) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        idle(90);
        // Reset mid-phase, then a fresh pulse.
        cyc(1'b1, 1'b0, 1'b1);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1);
        idle(12);
        // Pulse during high phase (retrigger or queue, depending on build).
        cyc(1'b1, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1);
        idle(25);
        // Randomized traffic with varying event density.
        for (int blk = 0; blk < 14; blk++) begin
            dens = 1 << (blk % 5);
            for (int j = 0; j < 200; j++) begin
                cyc(($urandom_range(dens - 1, 0) == 0),
                    ($urandom_range(31, 0) == 0),
                    ($urandom_range(299, 0) != 0));
            end
        end
        idle(100);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected vectors left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
